// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants and state encoding for the DDS sweep controller
package dds_pkg;

  localparam int DATA_LEN    = 8;
  localparam int ROWS_BASE_2 = 9;
  localparam int PHASE_W     = 9;
  localparam int FREQ_W      = 32;
  localparam int LUT_DEPTH   = 1 << ROWS_BASE_2;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] ST_PHASE = 3'd2;
  localparam logic [STATE_W-1:0] ST_STEP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DWELL = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/dds_dwell_timer.sv
// rtl/dds_dwell_timer.sv - loadable down-counter timing the dwell between sweep steps
module dds_dwell_timer (
  input  logic        src_clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  output logic        expire
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // A load of 0 is promoted to 1 so the dwell is never empty; otherwise count down and stop at 0
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (value == 32'd0) ? 32'd1 : value;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the last cycle of the loaded interval
  assign expire = (cnt_q == 32'd1);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - sequencer that loads the DDS table, sets phase and runs a chirp
module dds_sweep_ctrl #(
  parameter int DATA_LEN    = dds_pkg::DATA_LEN,
  parameter int ROWS_BASE_2 = dds_pkg::ROWS_BASE_2,
  parameter int PHASE_W     = dds_pkg::PHASE_W,
  parameter int FREQ_W      = dds_pkg::FREQ_W
) (
  input  logic                   src_clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   skip_load,
  input  logic [PHASE_W-1:0]     cfg_phase,
  input  logic [FREQ_W-1:0]      cfg_f_start,
  input  logic [FREQ_W-1:0]      cfg_f_stop,
  input  logic [FREQ_W-1:0]      cfg_f_step,
  input  logic [31:0]            cfg_dwell,
  input  logic [DATA_LEN-1:0]    lut_data,
  input  logic                   lut_valid,
  output logic                   lut_ready,
  output logic                   we,
  output logic [ROWS_BASE_2-1:0] addr_wr,
  output logic [DATA_LEN-1:0]    data_wr,
  output logic                   set_phase,
  output logic [PHASE_W-1:0]     phase,
  output logic                   set_freq,
  output logic [FREQ_W-1:0]      freq,
  output logic                   busy,
  output logic                   done
);

  import dds_pkg::*;

  logic [STATE_W-1:0]     state_q, state_d;
  logic [ROWS_BASE_2-1:0] cnt_q, cnt_d;
  logic [FREQ_W-1:0]      cur_q, cur_d;
  logic [PHASE_W-1:0]     cfg_phase_q, cfg_phase_d;
  logic [FREQ_W-1:0]      f_start_q, f_start_d;
  logic [FREQ_W-1:0]      f_stop_q, f_stop_d;
  logic [FREQ_W-1:0]      f_step_q, f_step_d;
  logic [31:0]            dwell_q, dwell_d;

  logic                   we_q, we_d;
  logic [ROWS_BASE_2-1:0] addr_wr_q, addr_wr_d;
  logic [DATA_LEN-1:0]    data_wr_q, data_wr_d;
  logic                   set_phase_q, set_phase_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic                   set_freq_q, set_freq_d;
  logic [FREQ_W-1:0]      freq_q, freq_d;
  logic                   done_q, done_d;

  logic [FREQ_W:0]        next_f;
  logic                   sweep_more;
  logic                   tmr_expire;

  // The dwell starts counting from the STEP cycle so DWELL lasts exactly max(dwell,1) cycles
  dds_dwell_timer u_dwell_timer (
    .src_clk (src_clk),
    .rst_n   (rst_n),
    .load    (state_q == ST_STEP),
    .value   (dwell_q),
    .expire  (tmr_expire)
  );

  // Next sweep point with a carry bit so wrap-around ends the sweep instead of restarting it
  always_comb begin
    next_f     = {1'b0, cur_q} + {1'b0, f_step_q};
    sweep_more = (f_step_q != '0) && !next_f[FREQ_W] && (next_f[FREQ_W-1:0] <= f_stop_q);
  end

  // Sequencer: strobes are computed on the transition into a state so they are registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    cfg_phase_d = cfg_phase_q;
    f_start_d   = f_start_q;
    f_stop_d    = f_stop_q;
    f_step_d    = f_step_q;
    dwell_d     = dwell_q;
    we_d        = 1'b0;
    addr_wr_d   = addr_wr_q;
    data_wr_d   = data_wr_q;
    set_phase_d = 1'b0;
    phase_d     = phase_q;
    set_freq_d  = 1'b0;
    freq_d      = freq_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cfg_phase_d = cfg_phase;
            f_start_d   = cfg_f_start;
            f_stop_d    = cfg_f_stop;
            f_step_d    = cfg_f_step;
            dwell_d     = cfg_dwell;
            if (skip_load) begin
              state_d     = ST_PHASE;
              set_phase_d = 1'b1;
              phase_d     = cfg_phase;
            end else begin
              state_d = ST_LOAD;
              cnt_d   = '0;
            end
          end
        end
        ST_LOAD: begin
          if (lut_valid) begin
            we_d      = 1'b1;
            addr_wr_d = cnt_q;
            data_wr_d = lut_data;
            cnt_d     = cnt_q + ROWS_BASE_2'(1);
            if (&cnt_q) begin
              state_d     = ST_PHASE;
              set_phase_d = 1'b1;
              phase_d     = cfg_phase_q;
            end
          end
        end
        ST_PHASE: begin
          cur_d      = f_start_q;
          set_freq_d = 1'b1;
          freq_d     = f_start_q;
          state_d    = ST_STEP;
        end
        ST_STEP: begin
          state_d = ST_DWELL;
        end
        ST_DWELL: begin
          if (tmr_expire) begin
            if (sweep_more) begin
              cur_d      = next_f[FREQ_W-1:0];
              set_freq_d = 1'b1;
              freq_d     = next_f[FREQ_W-1:0];
              state_d    = ST_STEP;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, configuration and output registers
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      cfg_phase_q <= '0;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_q     <= '0;
      we_q        <= 1'b0;
      addr_wr_q   <= '0;
      data_wr_q   <= '0;
      set_phase_q <= 1'b0;
      phase_q     <= '0;
      set_freq_q  <= 1'b0;
      freq_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      cfg_phase_q <= cfg_phase_d;
      f_start_q   <= f_start_d;
      f_stop_q    <= f_stop_d;
      f_step_q    <= f_step_d;
      dwell_q     <= dwell_d;
      we_q        <= we_d;
      addr_wr_q   <= addr_wr_d;
      data_wr_q   <= data_wr_d;
      set_phase_q <= set_phase_d;
      phase_q     <= phase_d;
      set_freq_q  <= set_freq_d;
      freq_q      <= freq_d;
      done_q      <= done_d;
    end
  end

  assign lut_ready = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign we        = we_q;
  assign addr_wr   = addr_wr_q;
  assign data_wr   = data_wr_q;
  assign set_phase = set_phase_q;
  assign phase     = phase_q;
  assign set_freq  = set_freq_q;
  assign freq      = freq_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

  logic        src_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        skip_load = 1'b0;
  logic [8:0]  cfg_phase = '0;
  logic [31:0] cfg_f_start = '0;
  logic [31:0] cfg_f_stop = '0;
  logic [31:0] cfg_f_step = '0;
  logic [31:0] cfg_dwell = '0;
  logic [7:0]  lut_data = '0;
  logic        lut_valid = 1'b0;
  logic        lut_ready;
  logic        we;
  logic [8:0]  addr_wr;
  logic [7:0]  data_wr;
  logic        set_phase;
  logic [8:0]  phase;
  logic        set_freq;
  logic [31:0] freq;
  logic        busy;
  logic        done;

  dds_sweep_ctrl dut (
    .src_clk     (src_clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .skip_load   (skip_load),
    .cfg_phase   (cfg_phase),
    .cfg_f_start (cfg_f_start),
    .cfg_f_stop  (cfg_f_stop),
    .cfg_f_step  (cfg_f_step),
    .cfg_dwell   (cfg_dwell),
    .lut_data    (lut_data),
    .lut_valid   (lut_valid),
    .lut_ready   (lut_ready),
    .we          (we),
    .addr_wr     (addr_wr),
    .data_wr     (data_wr),
    .set_phase   (set_phase),
    .phase       (phase),
    .set_freq    (set_freq),
    .freq        (freq),
    .busy        (busy),
    .done        (done)
  );

  always #5 src_clk = ~src_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge src_clk) cyc <= cyc + 1;

  int          w_addr[$];
  int          w_data[$];
  int          w_cyc[$];
  int          p_val[$];
  int          p_cyc[$];
  logic [31:0] f_val[$];
  int          f_cyc[$];
  int          d_cyc[$];
  int          b_fall[$];
  logic        busy_prev = 1'b0;
  logic [31:0] exp_f[$];
  logic [7:0]  samples[512];

  // Event log of every strobe, taken mid-cycle
  always @(negedge src_clk) begin
    if (rst_n) begin
      if (we) begin
        w_addr.push_back(int'(addr_wr));
        w_data.push_back(int'(data_wr));
        w_cyc.push_back(cyc);
      end
      if (set_phase) begin
        p_val.push_back(int'(phase));
        p_cyc.push_back(cyc);
      end
      if (set_freq) begin
        f_val.push_back(freq);
        f_cyc.push_back(cyc);
      end
      if (done) d_cyc.push_back(cyc);
      if (busy_prev && !busy) b_fall.push_back(cyc);
    end
    busy_prev <= busy;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    p_val.delete(); p_cyc.delete(); f_val.delete(); f_cyc.delete();
    d_cyc.delete(); b_fall.delete();
  endtask

  // Sweep points straight from the rule: start, then add step while it fits in 32 bits and stays <= stop
  function automatic void build_model(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st);
    longint unsigned n;
    exp_f.delete();
    exp_f.push_back(fs);
    if (st != 0) begin
      n = longint'(fs) + longint'(st);
      while (n <= 64'hFFFF_FFFF && n <= longint'(fe)) begin
        exp_f.push_back(n[31:0]);
        n = n + longint'(st);
      end
    end
  endfunction

  task automatic do_start(input bit skip, input logic [8:0] ph, input logic [31:0] fs,
                          input logic [31:0] fe, input logic [31:0] st, input logic [31:0] dw,
                          output int edge_c);
    @(posedge src_clk); #1;
    start = 1'b1; skip_load = skip; cfg_phase = ph;
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st; cfg_dwell = dw;
    @(posedge src_clk); #1;
    edge_c = cyc;
    start = 1'b0;
    cfg_phase = 9'($urandom); cfg_f_start = $urandom; cfg_f_stop = $urandom;
    cfg_f_step = $urandom; cfg_dwell = $urandom; skip_load = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({we, set_phase, set_freq, done, busy, lut_ready} !== 6'b0 || addr_wr !== 9'd0 ||
        data_wr !== 8'd0 || phase !== 9'd0 || freq !== 32'd0)
      begin bad++; $display("FAIL reset_outputs got strobes=%b addr=%0d data=%0d phase=%0d freq=%0d need all 0",
        {we, set_phase, set_freq, done, busy, lut_ready}, addr_wr, data_wr, phase, freq); end
    @(posedge src_clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge src_clk); #1;
    total++;
    if (busy !== 1'b0 || lut_ready !== 1'b0)
      begin bad++; $display("FAIL reset_idle got busy=%b lut_ready=%b need 0 0", busy, lut_ready); end
  endtask

  task automatic test_sweep(input string name, input logic [8:0] ph, input logic [31:0] fs,
                            input logic [31:0] fe, input logic [31:0] st, input logic [31:0] dw,
                            input bit poke);
    int e, n, lim, per, mis, pmis, last;
    clear_logs();
    build_model(fs, fe, st);
    per = 1 + ((dw == 0) ? 1 : int'(dw));
    lim = exp_f.size() * per + 20;
    do_start(1'b1, ph, fs, fe, st, dw, e);
    n = 0;
    while (busy === 1'b1 && n < lim) begin
      if (poke && (n == 3 || n == 17)) begin
        start = 1'b1; skip_load = 1'b0; cfg_f_start = $urandom; cfg_f_step = 32'd1;
        cfg_dwell = 32'd0; cfg_phase = 9'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge src_clk); #1;
      n++;
    end
    start = 1'b0;
    repeat (2) @(posedge src_clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s timeout busy=%b need 0", name, busy); end
    total++;
    if (p_cyc.size() != 1 || p_cyc[0] != e)
      begin bad++; $display("FAIL %s phase_time got n=%0d cyc=%0d need 1 at %0d", name, p_cyc.size(),
        (p_cyc.size() > 0) ? p_cyc[0] : -1, e); end
    total++;
    if (p_val.size() < 1 || p_val[0] != int'(ph))
      begin bad++; $display("FAIL %s phase_val got %0d need %0d", name, (p_val.size() > 0) ? p_val[0] : -1, ph); end
    total++;
    if (f_val.size() != exp_f.size())
      begin bad++; $display("FAIL %s freq_count got %0d need %0d", name, f_val.size(), exp_f.size()); end
    mis = 0; pmis = 0;
    for (int i = 0; i < f_val.size() && i < exp_f.size(); i++) begin
      if (f_val[i] !== exp_f[i]) mis++;
      if (i > 0 && f_cyc[i] - f_cyc[i-1] != per) pmis++;
    end
    total++;
    if (mis != 0) begin bad++; $display("FAIL %s freq_vals got %0d wrong values need 0", name, mis); end
    total++;
    if (pmis != 0) begin bad++; $display("FAIL %s period got %0d wrong gaps need 0 (period %0d)", name, pmis, per); end
    total++;
    if (f_cyc.size() < 1 || f_cyc[0] != e + 1)
      begin bad++; $display("FAIL %s first_freq got %0d need %0d", name, (f_cyc.size() > 0) ? f_cyc[0] : -1, e + 1); end
    last = (f_cyc.size() > 0) ? f_cyc[f_cyc.size()-1] : -1000;
    total++;
    if (d_cyc.size() != 1 || d_cyc[0] != last + per)
      begin bad++; $display("FAIL %s done_time got n=%0d cyc=%0d need 1 at %0d", name, d_cyc.size(),
        (d_cyc.size() > 0) ? d_cyc[0] : -1, last + per); end
    total++;
    if (b_fall.size() != 1 || d_cyc.size() < 1 || b_fall[0] != d_cyc[0] + 1)
      begin bad++; $display("FAIL %s busy_fall got %0d need done+1", name, (b_fall.size() > 0) ? b_fall[0] : -1); end
    total++;
    if (freq !== exp_f[exp_f.size()-1] || phase !== ph)
      begin bad++; $display("FAIL %s hold got freq=%0d phase=%0d need %0d %0d", name, freq, phase,
        exp_f[exp_f.size()-1], ph); end
  endtask

  // mode 0: valid always high, 1: valid toggles, 2: random valid with random data
  task automatic test_load(input string name, input int mode);
    int e, idx, g, rdy_err, mis, cmis, n;
    bit v, acc;
    int exp_wc[$];
    clear_logs();
    for (int i = 0; i < 512; i++) samples[i] = (mode == 0) ? 8'(i % 256) : 8'($urandom);
    do_start(1'b0, 9'd300, 32'd1000, 32'd1200, 32'd100, 32'd1, e);
    idx = 0; g = 0; rdy_err = 0;
    while (idx < 512 && g < 3000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (g % 2 == 0);
        default: v = 1'($urandom);
      endcase
      lut_valid = v; lut_data = samples[idx];
      @(negedge src_clk);
      if (lut_ready !== 1'b1) rdy_err++;
      acc = v && lut_ready;
      @(posedge src_clk); #1;
      if (acc) begin exp_wc.push_back(cyc); idx++; end
      g++;
    end
    lut_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin @(posedge src_clk); #1; n++; end
    repeat (2) @(posedge src_clk); #1;
    total++;
    if (idx != 512 || busy !== 1'b0) begin bad++; $display("FAIL %s timeout got beats=%0d busy=%b need 512 0", name, idx, busy); end
    total++;
    if (rdy_err != 0) begin bad++; $display("FAIL %s lut_ready got %0d low cycles in LOAD need 0", name, rdy_err); end
    total++;
    if (w_addr.size() != 512) begin bad++; $display("FAIL %s we_count got %0d need 512", name, w_addr.size()); end
    mis = 0; cmis = 0;
    for (int i = 0; i < w_addr.size() && i < 512; i++) begin
      if (w_addr[i] != i || w_data[i] != int'(samples[i])) mis++;
      if (i < exp_wc.size() && w_cyc[i] != exp_wc[i]) cmis++;
    end
    total++;
    if (mis != 0) begin bad++; $display("FAIL %s addr_data got %0d wrong writes need 0", name, mis); end
    total++;
    if (cmis != 0) begin bad++; $display("FAIL %s we_latency got %0d mistimed writes need 0", name, cmis); end
    total++;
    if (p_cyc.size() != 1 || w_cyc.size() == 0 || p_cyc[0] != w_cyc[w_cyc.size()-1] || p_val[0] != 300)
      begin bad++; $display("FAIL %s phase_at_last_we got n=%0d cyc=%0d need one at last we", name, p_cyc.size(),
        (p_cyc.size() > 0) ? p_cyc[0] : -1); end
    total++;
    if (f_val.size() != 3 || f_val[0] !== 32'd1000 || f_val[2] !== 32'd1200 || d_cyc.size() != 1 ||
        f_cyc[0] != p_cyc[0] + 1)
      begin bad++; $display("FAIL %s post_load_sweep got %0d strobes, %0d done need 3 1", name, f_val.size(), d_cyc.size()); end
  endtask

  task automatic test_abort_load();
    int e;
    clear_logs();
    for (int i = 0; i < 512; i++) samples[i] = 8'($urandom);
    do_start(1'b0, 9'd7, 32'd5, 32'd5, 32'd0, 32'd1, e);
    for (int i = 0; i < 100; i++) begin
      lut_valid = 1'b1; lut_data = samples[i];
      @(posedge src_clk); #1;
    end
    lut_valid = 1'b1; lut_data = samples[100]; abort = 1'b1;
    @(posedge src_clk); #1;
    abort = 1'b0; lut_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || lut_ready !== 1'b0)
      begin bad++; $display("FAIL abort_load_idle got busy=%b lut_ready=%b need 0 0", busy, lut_ready); end
    @(negedge src_clk);
    total++;
    if (we !== 1'b0) begin bad++; $display("FAIL abort_load_we got %b need 0", we); end
    repeat (20) @(posedge src_clk); #1;
    total++;
    if (w_addr.size() != 100 || addr_wr !== 9'd99)
      begin bad++; $display("FAIL abort_load_writes got n=%0d addr=%0d need 100 99", w_addr.size(), addr_wr); end
    total++;
    if (p_val.size() != 0 || d_cyc.size() != 0 || f_val.size() != 0)
      begin bad++; $display("FAIL abort_load_quiet got phase=%0d freq=%0d done=%0d need 0 0 0",
        p_val.size(), f_val.size(), d_cyc.size()); end
  endtask

  task automatic test_abort_dwell();
    int e, n;
    clear_logs();
    do_start(1'b1, 9'd88, 32'd100, 32'd10000, 32'd50, 32'd20, e);
    n = 0;
    while (f_val.size() < 2 && n < 200) begin @(posedge src_clk); #1; n++; end
    repeat (5) @(posedge src_clk); #1;
    abort = 1'b1;
    @(posedge src_clk); #1;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || set_freq !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL abort_dwell_idle got busy=%b set_freq=%b done=%b need 0", busy, set_freq, done); end
    repeat (50) @(posedge src_clk); #1;
    total++;
    if (f_val.size() != 2 || d_cyc.size() != 0)
      begin bad++; $display("FAIL abort_dwell_quiet got strobes=%0d done=%0d need 2 0", f_val.size(), d_cyc.size()); end
    total++;
    if (freq !== 32'd150 || phase !== 9'd88)
      begin bad++; $display("FAIL abort_dwell_hold got freq=%0d phase=%0d need 150 88", freq, phase); end
  endtask

  task automatic test_reset_mid();
    int e;
    clear_logs();
    do_start(1'b1, 9'd45, 32'd500, 32'd6400, 32'd100, 32'd3, e);
    repeat (30) @(posedge src_clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({we, set_phase, set_freq, done, busy, lut_ready} !== 6'b0 || addr_wr !== 9'd0 ||
        data_wr !== 8'd0 || phase !== 9'd0 || freq !== 32'd0)
      begin bad++; $display("FAIL reset_mid got strobes=%b phase=%0d freq=%0d need all 0",
        {we, set_phase, set_freq, done, busy, lut_ready}, phase, freq); end
    @(posedge src_clk); #1; rst_n = 1'b1;
    repeat (5) @(posedge src_clk); #1;
    total++;
    if (busy !== 1'b0 || freq !== 32'd0)
      begin bad++; $display("FAIL reset_mid_after got busy=%b freq=%0d need 0 0", busy, freq); end
  endtask

  task automatic test_start_abort_idle();
    clear_logs();
    @(posedge src_clk); #1;
    start = 1'b1; abort = 1'b1; skip_load = 1'b1; cfg_f_start = 32'd9; cfg_f_stop = 32'd9;
    @(posedge src_clk); #1;
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_busy got %b need 0", busy); end
    repeat (5) @(posedge src_clk); #1;
    total++;
    if (p_val.size() != 0 || f_val.size() != 0)
      begin bad++; $display("FAIL start_abort_quiet got phase=%0d freq=%0d strobes need 0 0", p_val.size(), f_val.size()); end
  endtask

  task automatic test_random_sweeps();
    logic [31:0] fs, fe, st;
    for (int k = 0; k < 4; k++) begin
      fs = $urandom_range(0, 5000);
      st = $urandom_range(50, 400);
      fe = (k == 3) ? fs - 32'd1 : fs + $urandom_range(0, 4000);
      test_sweep("rand_sweep", 9'($urandom), fs, fe, st, $urandom_range(0, 4), 1'b0);
    end
    fs = 32'hFFFF_FFFF - $urandom_range(0, 1000);
    test_sweep("rand_carry", 9'($urandom), fs, 32'hFFFF_FFFF, $urandom_range(100, 400), $urandom_range(0, 3), 1'b0);
  endtask

  initial begin
    test_reset();
    test_load("full_load", 0);
    test_load("backpressure", 1);
    test_sweep("chirp", 9'd45, 32'd500, 32'd6400, 32'd100, 32'd10, 1'b0);
    test_sweep("step_zero", 9'd1, 32'd777, 32'd6400, 32'd0, 32'd2, 1'b0);
    test_sweep("start_gt_stop", 9'd2, 32'd7000, 32'd6400, 32'd100, 32'd2, 1'b0);
    test_sweep("carry", 9'd3, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 32'd1, 1'b0);
    test_sweep("dwell_zero", 9'd4, 32'd10, 32'd60, 32'd10, 32'd0, 1'b0);
    test_abort_load();
    test_load("load_after_abort", 2);
    test_abort_dwell();
    test_sweep("after_abort_dwell", 9'd5, 32'd20, 32'd80, 32'd20, 32'd1, 1'b0);
    test_reset_mid();
    test_start_abort_idle();
    test_sweep("start_while_busy", 9'd6, 32'd500, 32'd1500, 32'd100, 32'd3, 1'b1);
    test_random_sweeps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
